// File: rtl/lcd_text_ctrl.sv
// rtl/lcd_text_ctrl.sv - HD44780-style 16x2 character LCD controller with cursor tracking and busy polling
// Optional busy-poll timeout enabled by defining LCD_BUSY_TIMEOUT_EN.
module lcd_text_ctrl #(
  parameter int DATA_BYTES   = 4,
  parameter int EN_HIGH_CYC  = 20,
  parameter int EN_LOW_CYC   = 22,
  parameter int POWERUP_CYC  = 750000,
  parameter int COLS         = 16,
  parameter int ROWS         = 2,
  parameter int BUSY_TIMEOUT = 4000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [8*DATA_BYTES-1:0]           wr_data,
  input  logic [$clog2(DATA_BYTES+1)-1:0]   wr_len,
  input  logic                              wr_cmd,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  output logic [$clog2(COLS)-1:0]           cur_col,
  output logic                              cur_row,
  output logic                              err_timeout,
  inout  wire  [7:0]                        LCD_DATA,
  output logic                              LCD_RW,
  output logic                              LCD_RS,
  output logic                              LCD_EN,
  output logic                              LCD_ON,
  output logic                              LCD_BLON
);

  localparam int LW  = $clog2(DATA_BYTES + 1);
  localparam int CW  = $clog2(COLS);
  localparam int MSB = 8 * DATA_BYTES - 1;

  typedef enum logic [3:0] {
    PWR_WAIT, INIT, IDLE, LOAD, WR_H, WR_L, POLL_H, POLL_L, POLL_CHK, WRAP
  } stateT;

  // What the byte currently on the bus belongs to; decides where to go after its poll.
  typedef enum logic [2:0] {PH_INIT, PH_DATA, PH_WRAP, PH_CMD, PH_NONE} phaseT;

  stateT               state, nextState;
  phaseT               phase;
  logic [31:0]         cnt;
  logic [1:0]          initIdx;
  logic [7:0]          byteReg;
  logic                rsReg;
  logic [MSB:0]        shiftReg;
  logic [LW-1:0]       remain;
  logic [LW-1:0]       lenClamp;
  logic                busyReg;
  logic                powerOn;
  logic                lcdRw;
  logic                pollAgain;
  logic                timeoutHit;
  logic [CW:0]         colInc;
  logic                wrapNow;

  function automatic logic [7:0] initCmd(input logic [1:0] idx);
    case (idx)
      2'd0:    initCmd = 8'h38;
      2'd1:    initCmd = 8'h0C;
      2'd2:    initCmd = 8'h01;
      default: initCmd = 8'h06;
    endcase
  endfunction

  assign lenClamp  = (wr_len > LW'(DATA_BYTES)) ? LW'(DATA_BYTES) : wr_len;
  assign colInc    = {1'b0, cur_col} + (CW+1)'(1);
  assign wrapNow   = (colInc == (CW+1)'(COLS));
  assign pollAgain = busyReg && !timeoutHit;
  assign LCD_DATA  = lcdRw ? 8'hzz : byteReg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= PWR_WAIT;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      PWR_WAIT: if (cnt == 32'(POWERUP_CYC - 1)) nextState = INIT;
      INIT:     nextState = LOAD;
      IDLE:     if (wr_valid) nextState = (wr_cmd || lenClamp != '0) ? LOAD : POLL_CHK;
      LOAD:     nextState = WR_H;
      WR_H:     if (cnt == 32'(EN_HIGH_CYC - 1)) nextState = WR_L;
      WR_L:     if (cnt == 32'(EN_LOW_CYC - 1)) nextState = POLL_H;
      POLL_H:   if (cnt == 32'(EN_HIGH_CYC - 1)) nextState = POLL_L;
      POLL_L:   if (cnt == 32'(EN_LOW_CYC - 1)) nextState = POLL_CHK;
      POLL_CHK: begin
        if (pollAgain) nextState = POLL_H;
        else begin
          case (phase)
            PH_INIT: nextState = (initIdx == 2'd3) ? IDLE : INIT;
            PH_DATA: nextState = wrapNow ? WRAP : ((remain != '0) ? LOAD : IDLE);
            PH_WRAP: nextState = (remain != '0) ? LOAD : IDLE;
            default: nextState = IDLE;
          endcase
        end
      end
      WRAP:     nextState = LOAD;
      default:  nextState = PWR_WAIT;
    endcase
  end

  always_comb begin
    wr_ready = 1'b0;
    LCD_EN   = 1'b0;
    lcdRw    = 1'b0;
    LCD_RS   = rsReg;
    LCD_RW   = 1'b0;
    LCD_ON   = powerOn;
    LCD_BLON = powerOn;
    case (state)
      IDLE:             wr_ready = 1'b1;
      WR_H:             LCD_EN = 1'b1;
      POLL_H:           begin LCD_EN = 1'b1; lcdRw = 1'b1; LCD_RS = 1'b0; end
      POLL_L, POLL_CHK: begin lcdRw = 1'b1; LCD_RS = 1'b0; end
      default:          ;
    endcase
    LCD_RW = lcdRw;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else if (state != nextState) cnt <= '0;
    else cnt <= cnt + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase    <= PH_NONE;
      initIdx  <= '0;
      byteReg  <= '0;
      rsReg    <= 1'b0;
      shiftReg <= '0;
      remain   <= '0;
      busyReg  <= 1'b0;
      powerOn  <= 1'b0;
      cur_col  <= '0;
      cur_row  <= 1'b0;
    end else begin
      powerOn <= 1'b1;
      case (state)
        INIT: begin
          byteReg <= initCmd(initIdx);
          rsReg   <= 1'b0;
          phase   <= PH_INIT;
        end
        IDLE: begin
          busyReg <= 1'b0;
          if (wr_valid) begin
            if (wr_cmd) begin
              byteReg <= wr_data[7:0];
              rsReg   <= 1'b0;
              remain  <= '0;
              phase   <= PH_CMD;
            end else begin
              byteReg  <= wr_data[MSB -: 8];
              rsReg    <= 1'b1;
              shiftReg <= wr_data << 8;
              remain   <= (lenClamp == '0) ? '0 : lenClamp - LW'(1);
              phase    <= (lenClamp == '0) ? PH_NONE : PH_DATA;
            end
          end
        end
        POLL_H: if (cnt == 32'(EN_HIGH_CYC - 1)) busyReg <= LCD_DATA[7];
        WRAP: begin
          byteReg <= cur_row ? 8'hC0 : 8'h80;
          rsReg   <= 1'b0;
          phase   <= PH_WRAP;
        end
        POLL_CHK: if (!pollAgain) begin
          case (phase)
            PH_INIT: initIdx <= initIdx + 2'd1;
            PH_DATA, PH_WRAP: begin
              if (phase == PH_DATA && wrapNow) begin
                cur_col <= '0;
                cur_row <= (ROWS == 2) ? ~cur_row : 1'b0;
              end else begin
                if (phase == PH_DATA) cur_col <= colInc[CW-1:0];
                if (remain != '0) begin
                  byteReg  <= shiftReg[MSB -: 8];
                  shiftReg <= shiftReg << 8;
                  remain   <= remain - LW'(1);
                  rsReg    <= 1'b1;
                  phase    <= PH_DATA;
                end
              end
            end
            PH_CMD: begin
              if (byteReg == 8'h01 || byteReg == 8'h02) begin
                cur_col <= '0;
                cur_row <= 1'b0;
              end else if (byteReg[7]) begin
                cur_row <= byteReg[6];
                cur_col <= (byteReg[5:0] > 6'(COLS - 1)) ? CW'(COLS - 1) : CW'(byteReg[5:0]);
              end
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

`ifdef LCD_BUSY_TIMEOUT_EN
  localparam int PCW = $clog2(BUSY_TIMEOUT + 1);
  logic [PCW-1:0] pollCnt;

  // Give up on the byte once BUSY_TIMEOUT consecutive polls have all read busy.
  assign timeoutHit = busyReg && (pollCnt == PCW'(BUSY_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pollCnt     <= '0;
      err_timeout <= 1'b0;
    end else if (state == LOAD) begin
      pollCnt <= '0;
    end else if (state == POLL_CHK && busyReg) begin
      pollCnt <= pollCnt + PCW'(1);
      if (timeoutHit) err_timeout <= 1'b1;
    end
  end
`else
  assign timeoutHit  = 1'b0;
  assign err_timeout = (BUSY_TIMEOUT < 0);
`endif

endmodule
